// File: rtl/page_cache_ctrl.sv
// Page cache controller: maps 24-bit CPU addresses onto WAYS SRAM page slots,
// stretching phi2 while pages are written back to or loaded from DRAM.
module page_cache_ctrl #(
  parameter int  WAYS      = 4,
  parameter int  PAGE_BITS = 14,
  localparam int WAY_BITS  = $clog2(WAYS)
) (
  input  logic                 fpgaClk,
  input  logic                 reset,
  input  logic [15:0]          a,
  input  logic [7:0]           d,
  input  logic                 rw,
  output logic                 phi2,
  output logic [WAY_BITS-1:0]  sram_addr,
  output logic                 sram_ce,
  output logic                 sram_we,
  output logic                 flush_req,
  output logic [PAGE_BITS-1:0] flush_page,
  output logic [WAY_BITS-1:0]  flush_way,
  output logic                 fill_req,
  output logic [PAGE_BITS-1:0] fill_page,
  output logic [WAY_BITS-1:0]  fill_way,
  input  logic                 mem_ack,
  output logic [15:0]          hit_cnt,
  output logic [15:0]          miss_cnt,
  output logic [3:0]           state_dbg
);

  // Bit 3 of the encoding is phi2: high while the CPU is held mid-cycle.
  typedef enum logic [3:0] {
    S_IDLE     = 4'b0000,
    S_LATCH    = 4'b0001,
    S_LOOKUP   = 4'b1000,
    S_ACCESS   = 4'b1001,
    S_EVICT    = 4'b1100,
    S_FLUSH    = 4'b1101,
    S_FILL     = 4'b1110,
    S_FILLWAIT = 4'b1111
  } state_t;

  state_t               state_q, state_d;
  logic [23:0]          addr_q, addr_d;
  logic                 rw_q, rw_d;
  logic [PAGE_BITS-1:0] tag_q [WAYS];
  logic [PAGE_BITS-1:0] tag_d [WAYS];
  logic [WAYS-1:0]      valid_q, valid_d;
  logic [WAYS-1:0]      dirty_q, dirty_d;
  logic [WAY_BITS-1:0]  victim_q, victim_d;
  logic [15:0]          hit_cnt_q, hit_cnt_d;
  logic [15:0]          miss_cnt_q, miss_cnt_d;

  logic [PAGE_BITS-1:0] page;
  logic                 hit_any;
  logic [WAY_BITS-1:0]  hit_way;
  logic                 unused_offset_bits;

  assign page               = addr_q[23 -: PAGE_BITS];
  assign unused_offset_bits = ^addr_q[23-PAGE_BITS:0];

  // A page is only ever loaded into one way, so at most one tag matches.
  always_comb begin
    hit_any = 1'b0;
    hit_way = '0;
    for (int i = 0; i < WAYS; i++) begin
      if (valid_q[i] && (tag_q[i] == page)) begin
        hit_any = 1'b1;
        hit_way = WAY_BITS'(i);
      end
    end
  end

  // DRAM handshake: flush_req/fill_req stay high, with page and way stable,
  // until a single-cycle mem_ack; mem_ack in any other state has no effect.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rw_d       = rw_q;
    tag_d      = tag_q;
    valid_d    = valid_q;
    dirty_d    = dirty_q;
    victim_d   = victim_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    case (state_q)
      S_IDLE:  state_d = S_LATCH;
      S_LATCH: begin
        addr_d  = {d, a};
        rw_d    = rw;
        state_d = S_LOOKUP;
      end
      S_LOOKUP: begin
        if (hit_any) begin
          state_d = S_ACCESS;
          if (hit_cnt_q != 16'hFFFF) hit_cnt_d = hit_cnt_q + 16'd1;
        end else begin
          state_d = S_EVICT;
          if (miss_cnt_q != 16'hFFFF) miss_cnt_d = miss_cnt_q + 16'd1;
        end
      end
      S_ACCESS: begin
        if (!rw_q) dirty_d[hit_way] = 1'b1;
        state_d = S_IDLE;
      end
      S_EVICT: begin
        state_d = (valid_q[victim_q] && dirty_q[victim_q]) ? S_FLUSH : S_FILL;
      end
      S_FLUSH: begin
        if (mem_ack) begin
          dirty_d[victim_q] = 1'b0;
          state_d           = S_FILL;
        end
      end
      S_FILL: begin
        if (mem_ack) begin
          tag_d[victim_q]   = page;
          valid_d[victim_q] = 1'b1;
          dirty_d[victim_q] = 1'b0;
          victim_d          = victim_q + 1'b1;
          state_d           = S_FILLWAIT;
        end
      end
      S_FILLWAIT: state_d = S_ACCESS;
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge fpgaClk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      rw_q       <= 1'b1;
      for (int i = 0; i < WAYS; i++) tag_q[i] <= '0;
      valid_q    <= '0;
      dirty_q    <= '0;
      victim_q   <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rw_q       <= rw_d;
      tag_q      <= tag_d;
      valid_q    <= valid_d;
      dirty_q    <= dirty_d;
      victim_q   <= victim_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign phi2       = state_q[3];
  assign sram_addr  = ((state_q == S_LOOKUP) || (state_q == S_ACCESS)) ? hit_way : '0;
  assign sram_ce    = (state_q == S_ACCESS);
  assign sram_we    = (state_q == S_ACCESS) && !rw_q;
  assign flush_req  = (state_q == S_FLUSH);
  assign flush_page = tag_q[victim_q];
  assign flush_way  = victim_q;
  assign fill_req   = (state_q == S_FILL);
  assign fill_page  = page;
  assign fill_way   = victim_q;
  assign hit_cnt    = hit_cnt_q;
  assign miss_cnt   = miss_cnt_q;
  assign state_dbg  = state_q;

endmodule
